// File: rtl/run_scheduler_if.sv
// Handshake between the run scheduler and the shared phase_extract instance.
// The master drives the run start pulse; the slave returns the end-of-packet phase.
interface run_scheduler_if;
  logic        start;
  logic        valid;
  logic        eop;
  logic [15:0] phase;

  modport master (output start, input valid, eop, phase);
  modport slave  (input start, output valid, eop, phase);
endinterface

// File: rtl/run_scheduler.sv
// Time-shares one phase_extract across NANT antennas: per frame, each antenna is selected,
// settled, started, and its end-of-packet phase (or a timeout marker) is captured.
module run_scheduler #(
  parameter int NANT    = 3,
  parameter int PERIOD  = 5000,
  parameter int SETTLE  = 4,
  parameter int TIMEOUT = 4096,
  localparam int SELW   = (NANT > 1) ? $clog2(NANT) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable_i,
  output logic [SELW-1:0]      sel_o,
  run_scheduler_if.master      pe,
  output logic [16*NANT-1:0]   phase_out_o,
  output logic [NANT-1:0]      timeout_mask_o,
  output logic                 frame_valid_o,
  output logic                 overrun_o
);

  localparam int CW = $clog2(PERIOD);
  localparam int TW = $clog2(TIMEOUT);
  localparam int SW = $clog2(SETTLE + 1);

  typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_START, S_BUSY, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [SELW-1:0]   ant_q, ant_d;
  logic [SW-1:0]     scnt_q, scnt_d;
  logic [TW-1:0]     tcnt_q, tcnt_d;
  logic              overrun_q, overrun_d;
  logic [15:0]       shadow_q [NANT];
  logic [NANT-1:0]   tmask_q;
  logic [16*NANT-1:0] phase_q;
  logic [NANT-1:0]   mask_q;

  logic              cap_en;
  logic              cap_to;
  logic [15:0]       cap_val;
  logic              last_ant;

  always_comb begin
    state_d   = state_q;
    ant_d     = ant_q;
    scnt_d    = scnt_q;
    tcnt_d    = tcnt_q;
    cap_en    = 1'b0;
    cap_to    = 1'b0;
    cap_val   = '0;
    last_ant  = (ant_q == SELW'(NANT - 1));

    if (!enable_i || cnt_q == CW'(PERIOD - 1)) cnt_d = '0;
    else                                         cnt_d = cnt_q + CW'(1);

    unique case (state_q)
      S_IDLE: begin
        if (enable_i && cnt_q == '0) begin
          ant_d   = '0;
          scnt_d  = SW'(SETTLE - 1);
          state_d = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (scnt_q == '0) state_d = S_START;
        else              scnt_d  = scnt_q - SW'(1);
      end
      S_START: begin
        tcnt_d  = '0;
        state_d = S_BUSY;
      end
      S_BUSY: begin
        tcnt_d = tcnt_q + TW'(1);
        // A real end-of-packet beats a simultaneous timeout.
        if (pe.valid && pe.eop) begin
          cap_en  = 1'b1;
          cap_val = pe.phase;
        end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
          cap_en  = 1'b1;
          cap_to  = 1'b1;
          cap_val = 16'h8000;
        end
        if (cap_en) begin
          if (last_ant) begin
            state_d = S_DONE;
          end else begin
            ant_d   = ant_q + SELW'(1);
            scnt_d  = SW'(SETTLE - 1);
            state_d = S_SETTLE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    overrun_d = overrun_q | (enable_i && cnt_q == CW'(PERIOD - 1) && state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      ant_q     <= '0;
      scnt_q    <= '0;
      tcnt_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ant_q     <= ant_d;
      scnt_q    <= scnt_d;
      tcnt_q    <= tcnt_d;
      overrun_q <= overrun_d;
    end
  end

  // Outputs load only when the last slot is captured, taking that slot straight from the capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NANT; k++) shadow_q[k] <= '0;
      tmask_q <= '0;
      phase_q <= '0;
      mask_q  <= '0;
    end else if (cap_en) begin
      for (int k = 0; k < NANT; k++) begin
        if (ant_q == SELW'(k)) begin
          shadow_q[k] <= cap_val;
          tmask_q[k]  <= cap_to;
        end
        if (last_ant) begin
          phase_q[16*k +: 16] <= (ant_q == SELW'(k)) ? cap_val : shadow_q[k];
          mask_q[k]           <= (ant_q == SELW'(k)) ? cap_to  : tmask_q[k];
        end
      end
    end
  end

  assign sel_o          = ant_q;
  assign pe.start       = (state_q == S_START);
  assign frame_valid_o  = (state_q == S_DONE);
  assign phase_out_o    = phase_q;
  assign timeout_mask_o = mask_q;
  assign overrun_o      = overrun_q;

endmodule
